adder_sum_serializer: RTL



---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_acc_unit.sv | 23 ++
 rtl/adder_sum_serializer.sv | 84 ++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder sum serializer
package adder_pkg;
  localparam int NSAMP_DEF = 4;
  localparam int ACC_W_DEF = 10;
  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;
endpackage

// File: rtl/adder_acc_unit.sv
// rtl/adder_acc_unit.sv - combinational accumulate step with carry/saturation flag
// ADDSER_SAT_EN selects saturating accumulation; otherwise modulo wrap.
module adder_acc_unit
  import adder_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic [ACC_W-1:0]  acc_next_o,
  output logic              flag_o
);
  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc_i} + (ACC_W+1)'(din_i);

`ifdef ADDSER_SAT_EN
  assign acc_next_o = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next_o = sum[ACC_W-1:0];
`endif
  assign flag_o = sum[ACC_W];
endmodule

// File: rtl/adder_sum_serializer.sv
// rtl/adder_sum_serializer.sv - sums NSAMP adder results, emits the total as two bytes LSB first
// Optional ADDSER_SAT_EN (in adder_acc_unit) saturates the total instead of wrapping.
module adder_sum_serializer
  import adder_pkg::*;
#(
  parameter int NSAMP = NSAMP_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);
  state_e             state_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic [BYTE_W-1:0]  out_data_q;
  logic               ovf_q, carry_d;

  adder_acc_unit #(.ACC_W(ACC_W)) u_acc (
    .acc_i      (acc_q),
    .din_i      (in_data),
    .acc_next_o (acc_d),
    .flag_o     (carry_d)
  );

  assign in_ready  = ena && (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ACCUM);
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else if (ena) begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | carry_d;
            if (cnt_q == CNT_W'(NSAMP - 1)) begin
              cnt_q       <= '0;
              state_q     <= SEND_LO;
              out_data_q  <= acc_d[BYTE_W-1:0];
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SEND_LO: begin
          if (out_ready) begin
            state_q    <= SEND_HI;
            out_data_q <= BYTE_W'(acc_q >> BYTE_W);
          end
        end
        SEND_HI: begin
          // Frame state clears only once the high byte has been taken.
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule
